sevseg_scan_controller: RTL and testbench
=========================================

// Module: sevseg_scan_controller
// PURPOSE
//  Memory-mapped controller that time-multiplexes the 4-digit seven-segment display of the Niski board.
//  Holds a 16-bit hex value plus control bits written by the CPU bus, and scans one digit at a time.
//  Inserts a blanking gap between digits to prevent ghosting. Drives the SEVSEG_SEG/SEL pins directly.
// PARAMETERS
//  REFRESH_DIV   100000  clock cycles a digit stays lit (SHOW phase); must be >= 16
//  BLANK_CYCLES  1000    clock cycles with all digits off between digits (BLANK phase); must be >= 1
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous reset, active-high
//  bus_req    in   1   access request; held high until bus_ack
//  bus_wr     in   1   1 = write, 0 = read; valid with bus_req
//  bus_addr   in   1   0 = VALUE register, 1 = CTRL register
//  bus_wdata  in   16  write data
//  bus_rdata  out  16  read data, valid while bus_ack = 1
//  bus_ack    out  1   one-cycle completion pulse
//  seg        out  7   segments {g,f,e,d,c,b,a}, active-low
//  sel        out  4   digit select, active-low one-hot; sel[0] = rightmost digit
// BEHAVIOUR
//  Reset: bus_ack = 0, bus_rdata = 0, seg = 7'h7F, sel = 4'hF, VALUE = 16'h0000, CTRL = 16'h001F,
//    digit index = 0, FSM = BLANK, phase counter = 0. Reset mid-access drops the access; no ack follows.
//  Registers: VALUE[15:0] holds digits 3..0 (nibble n -> digit n). CTRL[3:0] = per-digit enable mask;
//    CTRL[4] = display enable. Unused CTRL bits read 0.
//  Bus: an access is accepted on an edge where bus_req = 1 and bus_ack = 0. On that edge bus_ack goes high
//    for exactly 1 cycle, the write commits, and bus_rdata is loaded. If req is still high on the next edge,
//    it is not re-accepted because ack = 1. Back-to-back accesses therefore complete every 2 cycles.
//  FSM: BLANK -> SHOW after BLANK_CYCLES cycles. SHOW -> BLANK after REFRESH_DIV cycles.
//    SHOW->BLANK increments the digit index, wrapping 3 -> 0. The phase counter clears on every transition.
//  Outputs are registered.
//    - In BLANK: sel = 4'hF and seg = 7'h7F.
//    - In SHOW: sel[idx] = 0 only if CTRL[4] and CTRL[idx] are both set; otherwise sel = 4'hF for that slot.
//    - Scan timing is unaffected by the enable bits.
//  Decode is hex 0-F, standard patterns. Examples: 0 = 7'h40, 8 = 7'h00, A = 7'h08, F = 7'h0E.
//  Write during SHOW: the new nibble appears on seg 1 cycle after the ack edge. The slot length is unchanged.
//  Simultaneous write to CTRL and SHOW->BLANK edge: the FSM transition takes priority in timing.
//    The new CTRL value governs from the next edge.
// CONFIGURATION
//  SEVSEG_DIMMING_EN defined:
//    - CTRL[11:8] = brightness B, reset 4'hF.
//    - In SHOW, sel is active only while phase counter bits [msb-3:msb] (top 4 bits of the REFRESH_DIV-range
//      counter) are <= B. B = 15 gives full on; B = 0 gives about 1/16 duty.
//    - CTRL[11:8] is readable.
//  SEVSEG_DIMMING_EN undefined: no brightness logic. CTRL[11:8] reads 0 and writes to it are ignored.
// TESTING (REFRESH_DIV = 16, BLANK_CYCLES = 2)
//  1. Release rst -> sel = 4'hF for 2 cycles, then sel = 4'hE and seg = 7'h40 for 16 cycles,
//     then 2 cycles blank, then sel = 4'hD.
//  2. Write VALUE = 16'hF8A0 -> digits 0..3 show 7'h40, 7'h08, 7'h00, 7'h0E; after sel = 4'h7 the scan wraps to 4'hE.
//  3. Write CTRL = 16'h0015 -> digits 1 and 3 keep sel = 4'hF in their slots; the 18-cycle slot period is unchanged.
//  4. Hold bus_req = 1 with a read of addr 0 after test 2 -> bus_ack pulses 1 cycle with rdata = 16'hF8A0;
//     the next ack comes 2 cycles later.
//  5. Assert rst during SHOW of digit 2 with bus_req high -> the next edge gives sel = 4'hF, seg = 7'h7F,
//     ack = 0, VALUE = 0.
//  6. With SEVSEG_DIMMING_EN, write CTRL = 16'h001F and set brightness to 3 -> each SHOW slot has sel active
//     for 4 of 16 cycles; without the macro, readback of CTRL[11:8] = 0.

Source files
------------

// File: rtl/sevseg_scan_controller.sv
// Bus-mapped VALUE/CTRL registers driving a 4-digit seven-segment scan with a blanking gap between digits.
// Defining SEVSEG_DIMMING_EN adds a brightness field in CTRL[11:8] that gates sel within each SHOW slot.
module sevseg_scan_controller #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_req,
    input  logic        bus_wr,
    input  logic        bus_addr,
    input  logic [15:0] bus_wdata,
    output logic [15:0] bus_rdata,
    output logic        bus_ack,
    output logic [6:0]  seg,
    output logic [3:0]  sel
);
    localparam int unsigned RW = $clog2(REFRESH_DIV);
    localparam int unsigned BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int unsigned CW = (RW > BW) ? RW : BW;

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    r_idx;
    logic [1:0]    w_idx_nxt;

    logic [15:0]   r_value;
    logic [4:0]    r_ctrl;
    logic          r_ack;
    logic [15:0]   r_rdata;
    logic [6:0]    r_seg;
    logic [3:0]    r_sel;

    logic          w_accept;
    logic [15:0]   w_ctrl_word;
    logic          w_dim_on;
    logic          w_lit;
    logic [3:0]    w_nib;

`ifdef SEVSEG_DIMMING_EN
    logic [3:0]    r_bright;
    logic          w_unused_wdata;

    assign w_unused_wdata = ^{bus_wdata[15:12], bus_wdata[7:5]};
    assign w_ctrl_word    = {4'h0, r_bright, 3'b000, r_ctrl};
    assign w_dim_on       = (w_cnt_nxt[RW-1 -: 4] <= r_bright);
`else
    logic          w_unused_wdata;

    assign w_unused_wdata = ^bus_wdata[15:5];
    assign w_ctrl_word    = {11'd0, r_ctrl};
    assign w_dim_on       = 1'b1;
`endif

    assign w_accept  = bus_req && !r_ack;
    assign bus_ack   = r_ack;
    assign bus_rdata = r_rdata;
    assign seg       = r_seg;
    assign sel       = r_sel;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0:    p = 7'h40;
            4'h1:    p = 7'h79;
            4'h2:    p = 7'h24;
            4'h3:    p = 7'h30;
            4'h4:    p = 7'h19;
            4'h5:    p = 7'h12;
            4'h6:    p = 7'h02;
            4'h7:    p = 7'h78;
            4'h8:    p = 7'h00;
            4'h9:    p = 7'h10;
            4'hA:    p = 7'h08;
            4'hB:    p = 7'h03;
            4'hC:    p = 7'h46;
            4'hD:    p = 7'h21;
            4'hE:    p = 7'h06;
            default: p = 7'h0E;
        endcase
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
            r_value <= '0;
            r_ctrl  <= 5'h1F;
`ifdef SEVSEG_DIMMING_EN
            r_bright <= 4'hF;
`endif
        end else begin
            r_ack <= w_accept;
            if (w_accept) begin
                r_rdata <= bus_addr ? w_ctrl_word : r_value;
                if (bus_wr && !bus_addr) begin
                    r_value <= bus_wdata;
                end
                if (bus_wr && bus_addr) begin
                    r_ctrl <= bus_wdata[4:0];
`ifdef SEVSEG_DIMMING_EN
                    r_bright <= bus_wdata[11:8];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_BLANK: begin
                if (r_cnt == CW'(BLANK_CYCLES - 1)) begin
                    w_state_nxt = ST_SHOW;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SHOW: begin
                if (r_cnt == CW'(REFRESH_DIV - 1)) begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = r_idx + 2'd1;
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Pins are registered from the next-state values so they line up with the phase they belong to.
    always_comb begin
        w_nib = r_value[{w_idx_nxt, 2'b00} +: 4];
        w_lit = (w_state_nxt == ST_SHOW) && r_ctrl[4] && r_ctrl[w_idx_nxt] && w_dim_on;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel <= 4'hF;
            r_seg <= 7'h7F;
        end else begin
            r_sel <= w_lit ? ~(4'b0001 << w_idx_nxt) : 4'hF;
            r_seg <= w_lit ? hex7(w_nib) : 7'h7F;
        end
    end
endmodule

// File: tb/tb_sevseg_scan_controller.sv
// Directed bench for sevseg_scan_controller; display and bus expectations flow through scoreboard queues.
// Honours SEVSEG_DIMMING_EN so the same bench covers both builds.
module tb_sevseg_scan_controller;
    localparam int RD   = 16;
    localparam int BC   = 2;
    localparam int SLOT = RD + BC;
`ifdef SEVSEG_DIMMING_EN
    localparam logic [15:0] CMASK = 16'h0F1F;
    localparam logic [15:0] CRST  = 16'h0F1F;
`else
    localparam logic [15:0] CMASK = 16'h001F;
    localparam logic [15:0] CRST  = 16'h001F;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_req;
    logic        bus_wr;
    logic        bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_ack;
    logic [6:0]  seg;
    logic [3:0]  sel;

    always #5 clk = ~clk;

    sevseg_scan_controller #(
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus_req  (bus_req),
        .bus_wr   (bus_wr),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ack  (bus_ack),
        .seg      (seg),
        .sel      (sel)
    );

    typedef struct {
        logic [3:0] sel;
        logic [6:0] seg;
        logic       seg_care;
    } disp_t;

    typedef struct {
        logic        is_rd;
        logic [15:0] data;
    } bus_t;

    disp_t dq[$];
    bus_t  bq[$];

    int n_assert = 0;
    int n_fail   = 0;
    int t        = 0;

    logic [15:0] m_val  = '0;
    logic [15:0] m_ctrl = CRST;
    logic        m_ack  = 1'b0;

    logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d: observed %h, expected %h", tag, t, obs, exp);
        end
    endtask

    function automatic disp_t exp_disp(input int tt, input logic [15:0] v, input logic [15:0] c);
        disp_t e;
        int    ph;
        int    d;
        logic  lit;
        ph = tt % SLOT;
        e.sel = 4'hF;
        e.seg = 7'h7F;
        e.seg_care = 1'b1;
        if (ph >= BC) begin
            d   = (tt / SLOT) % 4;
            lit = c[4] && c[d];
`ifdef SEVSEG_DIMMING_EN
            lit = lit && ((ph - BC) <= int'(c[11:8]));
`endif
            e.seg_care = lit;
            if (lit) begin
                e.sel = ~(4'b0001 << d);
                e.seg = dec_tab[v[4*d +: 4]];
            end
        end
        return e;
    endfunction

    // One clock: predict at the edge from pre-edge model state, compare at the falling edge.
    task automatic step();
        disp_t e;
        disp_t o;
        bus_t  b;
        logic  was_rst;
        @(posedge clk);
        was_rst = rst;
        if (was_rst) begin
            m_val  = '0;
            m_ctrl = CRST;
            m_ack  = 1'b0;
            bq.delete();
            t = 0;
            e.sel = 4'hF;
            e.seg = 7'h7F;
            e.seg_care = 1'b1;
            dq.push_back(e);
        end else begin
            t++;
            dq.push_back(exp_disp(t, m_val, m_ctrl));
            if (bus_req && !m_ack) begin
                b.is_rd = !bus_wr;
                b.data  = bus_addr ? m_ctrl : m_val;
                bq.push_back(b);
                if (bus_wr) begin
                    if (bus_addr) m_ctrl = bus_wdata & CMASK;
                    else          m_val  = bus_wdata;
                end
                m_ack = 1'b1;
            end else begin
                m_ack = 1'b0;
            end
        end
        @(negedge clk);
        o = dq.pop_front();
        chk("sel", 32'(sel), 32'(o.sel));
        if (o.seg_care) chk("seg", 32'(seg), 32'(o.seg));
        chk("ack", 32'(bus_ack), 32'(m_ack));
        if (m_ack && bq.size() > 0) begin
            b = bq.pop_front();
            if (b.is_rd) chk("rdata", 32'(bus_rdata), 32'(b.data));
        end
        if (was_rst) chk("rdata_rst", 32'(bus_rdata), 32'd0);
    endtask

    task automatic bus_access(input logic wr, input logic a, input logic [15:0] d);
        bus_req   = 1'b1;
        bus_wr    = wr;
        bus_addr  = a;
        bus_wdata = d;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus_ack === 1'b1) break;
        end
        chk("ack_seen", 32'(bus_ack), 32'd1);
        bus_req = 1'b0;
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        bus_req   = 1'b0;
        bus_wr    = 1'b0;
        bus_addr  = 1'b0;
        bus_wdata = '0;
        repeat (3) step();
        rst = 1'b0;
        repeat (80) step();

        bus_access(1'b1, 1'b0, 16'hF8A0);
        repeat (80) step();

        bus_req  = 1'b1;
        bus_wr   = 1'b0;
        bus_addr = 1'b0;
        repeat (6) step();
        bus_req = 1'b0;

        bus_access(1'b1, 1'b1, 16'h0015);
        repeat (80) step();
        bus_access(1'b0, 1'b1, 16'h0000);

        bus_access(1'b1, 1'b1, 16'h031F);
        bus_access(1'b0, 1'b1, 16'h0000);
        repeat (80) step();

        for (int i = 0; i < 100; i++) begin
            if (((t / SLOT) % 4 == 2) && (t % SLOT >= BC + 3)) break;
            step();
        end
        rst      = 1'b1;
        bus_req  = 1'b1;
        bus_wr   = 1'b0;
        bus_addr = 1'b0;
        step();
        rst     = 1'b0;
        bus_req = 1'b0;
        repeat (3) step();
        bus_access(1'b0, 1'b0, 16'h0000);
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
